// File: rtl/iadder_arb_pkg.sv
// iadder_arb_pkg
//   Shared definitions for the arbitrated approximate 16-bit adder:
//   FSM state encoding, operand/sum widths and default parameter values.
//   Imported by iadder_b16_core and iadder_arb_b16.
package iadder_arb_pkg;

  localparam int OP_W      = 16;  // operand width
  localparam int SUM_W     = 17;  // sum width (operand width + carry-out)
  localparam int NREQ_DEF  = 4;   // default number of requesters
  localparam int ABITS_DEF = 8;   // default number of approximated low bits

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/iadder_b16_core.sv
// iadder_b16_core
//   Combinational 16-bit adder shared by the arbiter.
//   Default build: approximate adder. The upper (16-ABITS) bits are added
//   exactly with carry-out into sum[16]; the low ABITS bits get no carry
//   chain. Each low bit is set if either operand bit is set, or if any
//   generate (a&b) occurs at that bit or above inside the low part.
//   With IADDER_ARB_EXACT_EN defined: exact 17-bit a+b, ABITS ignored.
// Ports
//   a, b : 16-bit operands
//   sum  : 17-bit result
module iadder_b16_core
  import iadder_arb_pkg::*;
#(
  parameter int ABITS = ABITS_DEF
) (
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic [SUM_W-1:0] sum
);

`ifdef IADDER_ARB_EXACT_EN

  assign sum = {1'b0, a} + {1'b0, b};

`else

  localparam int HW = OP_W - ABITS;

  logic [HW:0]       hi_sum;
  logic [ABITS-1:0]  gen_and;
  logic [ABITS-1:0]  lo_sum;

  // Exact upper part; the low part never feeds a carry into it.
  assign hi_sum  = {1'b0, a[OP_W-1:ABITS]} + {1'b0, b[OP_W-1:ABITS]};
  assign gen_and = a[ABITS-1:0] & b[ABITS-1:0];

  // A generate anywhere from bit gi up to the top of the low part would
  // have rippled ones down through bit gi, so saturate it to one.
  generate
    for (genvar gi = 0; gi < ABITS; gi++) begin : g_lo
      assign lo_sum[gi] = a[gi] | b[gi] | (|gen_and[ABITS-1:gi]);
    end
  endgenerate

  assign sum = {hi_sum, lo_sum};

`endif

endmodule

// File: rtl/iadder_arb_b16.sv
// iadder_arb_b16
//   Shares one 16-bit adder (iadder_b16_core) among NREQ requesters.
//   A three-state FSM (IDLE -> CALC -> DONE) accepts one request in IDLE
//   using a round-robin search starting at rr_ptr, computes the sum in
//   CALC, and holds the result in DONE until the consumer takes it.
//   rr_ptr only advances on result handoff, to one past the served index.
//   Build option: define IADDER_ARB_EXACT_EN for an exact adder.
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   req_valid  : per-requester operand valid
//   req_ready  : per-requester accept strobe (one-hot or zero, combinational)
//   req_a/b    : packed operands, requester i at [16i+15:16i]
//   res_valid  : result valid (held until res_ready)
//   res_ready  : result consumer ready
//   res_sum    : registered 17-bit sum
//   res_id     : index of the requester owning res_sum
module iadder_arb_b16
  import iadder_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int ABITS = ABITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*OP_W-1:0]     req_a,
  input  logic [NREQ*OP_W-1:0]     req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [SUM_W-1:0]         res_sum,
  output logic [$clog2(NREQ)-1:0]  res_id
);

  localparam int              IDW     = $clog2(NREQ);
  localparam logic [IDW:0]    NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0]  LAST_ID = IDW'(NREQ - 1);

  // Registered state
  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OP_W-1:0]  a_q, a_d;
  logic [OP_W-1:0]  b_q, b_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic             res_valid_q, res_valid_d;
  logic [SUM_W-1:0] res_sum_q, res_sum_d;
  logic [IDW-1:0]   res_id_q, res_id_d;

  // Arbitration
  logic [OP_W-1:0]   req_a_arr [NREQ];
  logic [OP_W-1:0]   req_b_arr [NREQ];
  logic [2*NREQ-1:0] rv_dbl;
  logic [NREQ-1:0]   rv_rot;
  logic [IDW-1:0]    off_sel;
  logic [IDW:0]      idx_sum;
  logic [IDW-1:0]    grant_idx;
  logic              grant_vld;
  logic [SUM_W-1:0]  core_sum;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_a_arr[gi] = req_a[gi*OP_W +: OP_W];
      assign req_b_arr[gi] = req_b[gi*OP_W +: OP_W];
    end
  endgenerate

  // Round-robin search: rotate the valid vector so bit k is requester
  // (rr_ptr + k) mod NREQ, take the lowest set bit, then rotate the
  // offset back into an absolute index.
  always_comb begin
    rv_dbl    = {req_valid, req_valid} >> rr_ptr_q;
    rv_rot    = rv_dbl[NREQ-1:0];
    grant_vld = |req_valid;
    off_sel   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rv_rot[k]) begin
        off_sel = IDW'(k);
      end
    end
    idx_sum = {1'b0, rr_ptr_q} + {1'b0, off_sel};
    if (idx_sum >= NREQ_W) begin
      idx_sum = idx_sum - NREQ_W;
    end
    grant_idx = idx_sum[IDW-1:0];
  end

  // The accept strobe is gated by reset so it drops the moment rst falls.
  always_comb begin
    req_ready = '0;
    if (rst && (state_q == IDLE) && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  iadder_b16_core #(
    .ABITS(ABITS)
  ) u_core (
    .a  (a_q),
    .b  (b_q),
    .sum(core_sum)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    gid_d       = gid_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          a_d     = req_a_arr[grant_idx];
          b_d     = req_b_arr[grant_idx];
          gid_d   = grant_idx;
          state_d = CALC;
        end
      end
      CALC: begin
        res_sum_d   = core_sum;
        res_id_d    = gid_q;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          rr_ptr_d    = (gid_q == LAST_ID) ? '0 : gid_q + IDW'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gid_q       <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gid_q       <= gid_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_iadder_arb_b16.sv
// tb_iadder_arb_b16
//   Self-checking bench for iadder_arb_b16 (NREQ=4, ABITS=8). Inputs are
//   driven 2 time units after each rising edge and outputs sampled 1 unit
//   later. Expected sums come from an arithmetic model of the approximate
//   (or, with IADDER_ARB_EXACT_EN, exact) addition; grants come from a
//   transaction-level round-robin model.
module tb_iadder_arb_b16;

  localparam int NREQ  = 4;
  localparam int ABITS = 8;
  localparam int IDW   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*16-1:0]   req_a;
  logic [NREQ*16-1:0]   req_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [16:0]          res_sum;
  logic [IDW-1:0]       res_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iadder_arb_b16 #(.NREQ(NREQ), .ABITS(ABITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum  (res_sum),
    .res_id   (res_id)
  );

  // Reference sum straight from the arithmetic rules.
  function automatic logic [16:0] model_sum(input logic [15:0] a, input logic [15:0] b);
`ifdef IADDER_ARB_EXACT_EN
    return 17'(int'(a) + int'(b));
`else
    int unsigned hi, gen, lo;
    hi  = (32'(a) >> ABITS) + (32'(b) >> ABITS);
    gen = 32'(a & b) & ((32'd1 << ABITS) - 32'd1);
    lo  = 0;
    for (int i = 0; i < ABITS; i++) begin
      if (a[i] || b[i] || ((gen >> i) != 0)) lo = lo | (32'd1 << i);
    end
    return 17'((hi << ABITS) | lo);
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_operands();
    for (int k = 0; k < NREQ; k++) begin
      req_a[k*16 +: 16] = 16'($urandom);
      req_b[k*16 +: 16] = 16'($urandom);
    end
  endtask

  // Round-robin choice among currently valid requesters, -1 if none.
  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b0; req_valid = '1; res_ready = 1'b1;
    rand_operands();
    for (int r = 0; r < 2; r++) begin
      #3;
      n_checks++;
      if (req_ready !== 4'b0) begin
        $display("FAIL reset_req_ready: got %b want 0000", req_ready); n_fail++;
      end
      n_checks++;
      if ({res_valid, res_sum, res_id} !== 20'b0) begin
        $display("FAIL reset_outputs: got valid=%b sum=%h id=%0d want all zero", res_valid, res_sum, res_id);
        n_fail++;
      end
      @(posedge clk);
      #2;
    end
    req_valid = '0; rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0 || res_valid !== 1'b0) begin
      $display("FAIL reset_release_idle: got ready=%b valid=%b want 0000/0", req_ready, res_valid); n_fail++;
    end
    next_cycle();
  endtask

  task automatic test_directed_sums();
    int         ids [2];
    logic [15:0] ta [2];
    logic [15:0] tb_op [2];
    logic [16:0] te [2];
    logic [NREQ-1:0] onehot;
    ids = '{0, 1};
    ta = '{16'h00FF, 16'h0180};
    tb_op = '{16'h0001, 16'h0280};
`ifdef IADDER_ARB_EXACT_EN
    te = '{17'h00100, 17'h00400};
`else
    te = '{17'h000FF, 17'h003FF};
`endif
    for (int t = 0; t < 2; t++) begin
      req_valid = '0; req_valid[ids[t]] = 1'b1;
      req_a[ids[t]*16 +: 16] = ta[t];
      req_b[ids[t]*16 +: 16] = tb_op[t];
      res_ready = 1'b0;
      onehot = '0; onehot[ids[t]] = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== onehot) begin
        $display("FAIL dir_grant%0d: got %b want %b", t, req_ready, onehot); n_fail++;
      end
      next_cycle();
      req_valid = '0;
      #1;
      n_checks++;
      if (req_ready !== 4'b0 || res_valid !== 1'b0) begin
        $display("FAIL dir_calc%0d: got ready=%b valid=%b want 0000/0", t, req_ready, res_valid); n_fail++;
      end
      next_cycle();
      n_checks++;
      if (res_valid !== 1'b1 || res_sum !== te[t] || res_id !== IDW'(ids[t])) begin
        $display("FAIL dir_result%0d: got valid=%b sum=%h id=%0d want 1 %h %0d",
                 t, res_valid, res_sum, res_id, te[t], ids[t]);
        n_fail++;
      end
      $display("txn dir id=%0d a=%h b=%h sum=%h", res_id, ta[t], tb_op[t], res_sum);
      res_ready = 1'b1;
      next_cycle();
      n_checks++;
      if (res_valid !== 1'b0) begin
        $display("FAIL dir_handoff%0d: got valid=%b want 0", t, res_valid); n_fail++;
      end
      res_ready = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    int n_acc = 0;
    int last_acc = -100;
    logic [16:0] pend_sum = '0;
    int pend_id = 0;
    logic [NREQ-1:0] onehot;
    rst = 1'b0;
    next_cycle();
    rst = 1'b1; req_valid = '1; res_ready = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      rand_operands();
      #1;
      n_checks++;
      if (res_valid !== (n_acc > 0 && cyc == last_acc + 2)) begin
        $display("FAIL rr_valid_timing: cycle %0d got %b", cyc, res_valid); n_fail++;
      end
      if (res_valid === 1'b1) begin
        n_checks++;
        if (res_sum !== pend_sum || res_id !== IDW'(pend_id)) begin
          $display("FAIL rr_result: got sum=%h id=%0d want %h %0d", res_sum, res_id, pend_sum, pend_id);
          n_fail++;
        end
        $display("txn rr id=%0d sum=%h", res_id, res_sum);
      end
      if (req_ready !== 4'b0) begin
        onehot = '0; onehot[n_acc % NREQ] = 1'b1;
        n_checks++;
        if (req_ready !== onehot) begin
          $display("FAIL rr_grant: got %b want %b", req_ready, onehot); n_fail++;
        end
        if (n_acc > 0) begin
          n_checks++;
          if (cyc - last_acc != 3) begin
            $display("FAIL rr_spacing: got %0d cycles want 3", cyc - last_acc); n_fail++;
          end
        end
        pend_id  = n_acc % NREQ;
        pend_sum = model_sum(req_a[pend_id*16 +: 16], req_b[pend_id*16 +: 16]);
        last_acc = cyc;
        n_acc++;
      end
      next_cycle();
    end
    n_checks++;
    if (n_acc != 5) begin
      $display("FAIL rr_accept_count: got %0d want 5", n_acc); n_fail++;
    end
    req_valid = '0; res_ready = 1'b0;
    next_cycle();
  endtask

  // rr_ptr is 1 here (last handoff served requester 0).
  task automatic test_stall();
    logic [16:0] exp_sum;
    req_valid = '1;
    rand_operands();
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      $display("FAIL stall_grant: got %b want 0010", req_ready); n_fail++;
    end
    exp_sum = model_sum(req_a[31:16], req_b[31:16]);
    next_cycle();
    next_cycle();
    for (int s = 0; s < 5; s++) begin
      rand_operands();
      #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_sum !== exp_sum || res_id !== 2'd1 || req_ready !== 4'b0) begin
        $display("FAIL stall_hold%0d: got valid=%b sum=%h id=%0d ready=%b want 1 %h 1 0000",
                 s, res_valid, res_sum, res_id, req_ready, exp_sum);
        n_fail++;
      end
      next_cycle();
    end
    $display("txn stall id=%0d sum=%h", res_id, res_sum);
    res_ready = 1'b1;
    next_cycle();
    req_valid = '0; res_ready = 1'b0;
    #1;
    n_checks++;
    if (res_valid !== 1'b0) begin
      $display("FAIL stall_release: got valid=%b want 0", res_valid); n_fail++;
    end
  endtask

  // rr_ptr is 2 here.
  task automatic test_reset_in_calc();
    req_a = {4{16'h1234}}; req_b = {4{16'h0101}};
    req_valid = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      $display("FAIL rcalc_wrap_grant: got %b want 0010", req_ready); n_fail++;
    end
    next_cycle();
    req_valid = '0;
    next_cycle();
    res_ready = 1'b1;
    next_cycle();
    res_ready = 1'b0; req_valid = '1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      $display("FAIL rcalc_grant: got %b want 0100", req_ready); n_fail++;
    end
    next_cycle();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({res_valid, res_sum, res_id} !== 20'b0 || req_ready !== 4'b0) begin
      $display("FAIL rcalc_async: got valid=%b sum=%h id=%0d ready=%b want all zero",
               res_valid, res_sum, res_id, req_ready);
      n_fail++;
    end
    next_cycle();
    req_valid = '0; rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      n_checks++;
      if (res_valid !== 1'b0) begin
        $display("FAIL rcalc_no_result%0d: got valid=%b want 0", s, res_valid); n_fail++;
      end
    end
    req_valid = '1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL rcalc_ptr_zero: got %b want 0001", req_ready); n_fail++;
    end
    next_cycle();
    req_valid = '0; res_ready = 1'b1;
    next_cycle();
    next_cycle();
    res_ready = 1'b0;
  endtask

  // rr_ptr is 1 here; only requester 0 valid, so the search wraps.
  task automatic test_pulse_in_done();
    req_valid = 4'b0001;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL pulse_first_grant: got %b want 0001", req_ready); n_fail++;
    end
    next_cycle();
    req_valid = '0;
    next_cycle();
    req_valid = 4'b0100;
    #1;
    n_checks++;
    if (req_ready !== 4'b0 || res_valid !== 1'b1) begin
      $display("FAIL pulse_in_done: got ready=%b valid=%b want 0000/1", req_ready, res_valid); n_fail++;
    end
    next_cycle();
    req_valid = '0; res_ready = 1'b1;
    next_cycle();
    res_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      n_checks++;
      if (req_ready !== 4'b0 || res_valid !== 1'b0) begin
        $display("FAIL pulse_idle%0d: got ready=%b valid=%b want 0000/0", s, req_ready, res_valid);
        n_fail++;
      end
    end
  endtask

  task automatic test_random();
    int mptr = 0;
    bit busy = 1'b0;
    int acc_cyc = 0;
    int pend_id = 0;
    logic [16:0] pend_sum = '0;
    logic [NREQ-1:0] exp_rdy;
    bit exp_rv;
    int g;
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid = ($urandom_range(3) == 0) ? '0 : NREQ'($urandom);
      res_ready = ($urandom_range(2) != 0);
      rand_operands();
      #1;
      exp_rdy = '0;
      g = busy ? -1 : rr_pick(mptr, req_valid);
      if (g >= 0) exp_rdy[g] = 1'b1;
      exp_rv = busy && (cyc >= acc_cyc + 2);
      n_checks++;
      if (req_ready !== exp_rdy || res_valid !== exp_rv) begin
        $display("FAIL rand_handshake: cycle %0d got ready=%b valid=%b want %b %b",
                 cyc, req_ready, res_valid, exp_rdy, exp_rv);
        n_fail++;
      end
      if (exp_rv) begin
        n_checks++;
        if (res_sum !== pend_sum || res_id !== IDW'(pend_id)) begin
          $display("FAIL rand_result: got sum=%h id=%0d want %h %0d", res_sum, res_id, pend_sum, pend_id);
          n_fail++;
        end
        if (res_ready) begin
          $display("txn rand id=%0d sum=%h", pend_id, pend_sum);
          busy = 1'b0;
          mptr = (pend_id + 1) % NREQ;
        end
      end else if (g >= 0) begin
        busy     = 1'b1;
        acc_cyc  = cyc;
        pend_id  = g;
        pend_sum = model_sum(req_a[g*16 +: 16], req_b[g*16 +: 16]);
      end
      next_cycle();
    end
    req_valid = '0; res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; res_ready = 1'b0; req_a = '0; req_b = '0;
    test_reset();
    test_directed_sums();
    test_round_robin();
    test_stall();
    test_reset_in_calc();
    test_pulse_in_done();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iadder_arb_b16.md
IADDER_ARB_B16 -- requirements
Module: iadder_arb_b16

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter ABITS, default 8, giving the number of approximated low-order sum bits (1..15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  per-requester operand-valid flag.
REQ-006 req_ready  output  NREQ  per-requester accept strobe; one-hot or zero.
REQ-007 req_a, req_b  input  NREQ*16 each  packed 16-bit operands; requester i occupies bits [16i+15:16i].
REQ-008 res_valid  output  1  result-valid flag.
REQ-009 res_ready  input  1  result consumer ready.
REQ-010 res_sum  output  17  registered sum.
REQ-011 res_id  output  clog2(NREQ)  index of the requester that owns res_sum.

Function
REQ-012 The block SHALL share one 16-bit approximate adder among NREQ requesters using a three-state FSM: IDLE, CALC, DONE.
REQ-013 IDLE: if any req_valid is high, the block SHALL grant by round-robin, searching from pointer rr_ptr upward with wrap.
- req_ready[g] high combinationally for the granted g only.
- Operands and g captured on that edge.
- Next state CALC.
REQ-014 IDLE with no req_valid SHALL keep req_ready all zero and stay in IDLE.
REQ-015 CALC SHALL last exactly one cycle: the adder result from the captured operands is registered into res_sum, res_id = g, and the FSM moves to DONE.
REQ-016 Latency: res_valid SHALL rise two edges after the accept edge.
REQ-017 DONE SHALL hold res_valid=1 with res_sum and res_id stable until res_valid & res_ready.
- On that edge: res_valid←0, rr_ptr←(g+1) mod NREQ, FSM→IDLE.
REQ-018 req_ready SHALL be zero in CALC and DONE; minimum spacing between accepts SHALL be 3 cycles.
REQ-019 Approximate sum, with L = ABITS:
- res_sum[16:L] = A[15:L] + B[15:L], zero-extended with carry-out; no carry from the low part.
- For i < L: res_sum[i] = (A[i]|B[i]) | OR over j = i..L-1 of (A[j]&B[j]).
REQ-020 A requester dropping req_valid while not granted SHALL be legal; the grant SHALL never go to a requester whose req_valid is low in that cycle.
REQ-021 rr_ptr SHALL change only on result handoff, so every continuously-valid requester is served within NREQ transactions.

Reset
REQ-022 While rst=0, the block SHALL force, asynchronously:
- FSM=IDLE, rr_ptr=0
- res_valid=0, res_sum=0, res_id=0
- captured operands=0, req_ready=0.
REQ-023 Reset asserted in CALC or DONE SHALL discard the in-flight transaction; no res_valid follows the reset release.
REQ-024 The first grant after reset release SHALL occur no earlier than the first rising edge with rst=1.

Configuration
REQ-025 Macro IADDER_ARB_EXACT_EN SHALL control the adder mode:
- Defined: res_sum = A + B, exact 17-bit; ABITS ignored.
- Undefined: approximate sum per REQ-019.
- Timing and handshake identical in both modes.

Structure
REQ-026 Package iadder_arb_pkg SHALL hold:
- the FSM state enum (IDLE, CALC, DONE)
- operand width constant 16 and sum width constant 17
- the default values of NREQ and ABITS.
REQ-027 The adder SHALL be a combinational sub-module iadder_b16_core (A, B → 17-bit SUM, parameter ABITS, honouring IADDER_ARB_EXACT_EN), instantiated once; the FSM, arbiter and registers remain in iadder_arb_b16.

Verification
REQ-028 Approximate mode, NREQ=4, ABITS=8, req 0 sends A=0x00FF, B=0x0001 -> res_sum=0x000FF, res_id=0, res_valid two edges after accept; with the exact macro -> 0x00100.
REQ-029 Approximate mode, A=0x0180, B=0x0280 -> res_sum=0x003FF; exact -> 0x00400.
REQ-030 All four req_valid held high with res_ready=1 -> grants 0,1,2,3,0, one accept every 3 cycles.
REQ-031 res_ready=0 for 5 cycles in DONE -> res_valid, res_sum and res_id stable; req_ready all zero; no new grant.
REQ-032 rst pulled low during CALC -> all outputs 0 immediately; after release, the next grant comes from rr_ptr=0.
REQ-033 req_valid[2] only, pulsed for 1 cycle while the FSM is in DONE -> no grant to requester 2; a later IDLE with no valid -> stays IDLE.
